// File: rtl/pulse_stretch_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
package pulse_stretch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Width of the hold/gap tick counters; both must be able to hold their load value.
   function automatic int unsigned cnt_width(input int unsigned hold_ticks,
                                             input int unsigned gap_ticks);
      int unsigned max_ticks;
      max_ticks = (hold_ticks > gap_ticks) ? hold_ticks : gap_ticks;
      return $clog2(max_ticks + 1);
   endfunction

   // Width of the clk_in-per-tick divider counter (at least one bit).
   function automatic int unsigned div_width(input int unsigned tick_div);
      return (tick_div > 1) ? $clog2(tick_div) : 1;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Timing tick generator: one tick every TICK_DIV cycles, realigned by restart_in.
module tick_gen
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk_in,
   input  logic reset_in,
   input  logic restart_in,
   output logic tick_out
);

   localparam int unsigned DW = div_width(TICK_DIV);
   localparam logic [DW-1:0] CNT_LAST = DW'(TICK_DIV - 1);
   localparam logic [DW-1:0] CNT_ONE = DW'(1);

   if (TICK_DIV < 1) begin : g_bad_div
      $error("TICK_DIV must be >= 1");
   end

   logic [DW-1:0] r_cnt;
   logic [DW-1:0] w_cnt_nxt;
   logic          w_at_last;

   assign w_at_last = (r_cnt == CNT_LAST);
   assign tick_out  = w_at_last && !restart_in;

   always_comb begin
      w_cnt_nxt = r_cnt + CNT_ONE;
      if (restart_in || w_at_last) begin
         w_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns one-cycle requests into timed high levels followed by a
// guaranteed low gap, with one queued request and a drop flag on overflow.
module pulse_stretcher
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 4,
   parameter int unsigned HOLD_TICKS = 3,
   parameter int unsigned GAP_TICKS  = 2,
   parameter bit          RETRIGGER  = 1'b0
) (
   input  logic clk_in,
   input  logic reset_in,
   input  logic pulse_in,
   output logic level_out,
   output logic busy_out,
   output logic drop_out
);

   localparam int unsigned CW = cnt_width(HOLD_TICKS, GAP_TICKS);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_TICKS);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_TICKS);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   if (HOLD_TICKS < 1) begin : g_bad_hold
      $error("HOLD_TICKS must be >= 1");
   end
   if (GAP_TICKS < 1) begin : g_bad_gap
      $error("GAP_TICKS must be >= 1");
   end

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_hold_cnt;
   logic [CW-1:0] w_hold_nxt;
   logic [CW-1:0] r_gap_cnt;
   logic [CW-1:0] w_gap_nxt;
   logic          r_pending;
   logic          w_pend_nxt;
   logic          r_level;
   logic          r_busy;
   logic          r_drop;
   logic          w_level_nxt;
   logic          w_busy_nxt;
   logic          w_drop_nxt;
   logic          w_restart;
   logic          w_tick;

   // Only pulse-driven HOLD entries need an explicit restart; tick-driven transitions
   // happen on the divider's last count, so it wraps to zero on its own.
   assign w_restart = pulse_in && ((r_state == IDLE) || (RETRIGGER && (r_state == HOLD)));

   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .restart_in(w_restart),
      .tick_out  (w_tick)
   );

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state    <= IDLE;
         r_hold_cnt <= '0;
         r_gap_cnt  <= '0;
         r_pending  <= 1'b0;
         r_level    <= 1'b0;
         r_busy     <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_gap_cnt  <= w_gap_nxt;
         r_pending  <= w_pend_nxt;
         r_level    <= w_level_nxt;
         r_busy     <= w_busy_nxt;
         r_drop     <= w_drop_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_gap_nxt   = r_gap_cnt;
      w_pend_nxt  = r_pending;
      w_drop_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (pulse_in) begin
               w_state_nxt = HOLD;
               w_hold_nxt  = HOLD_LD;
            end
         end
         HOLD: begin
            if (RETRIGGER && pulse_in) begin
               w_hold_nxt = HOLD_LD;
            end else begin
               if (pulse_in) begin
                  if (r_pending) begin
                     w_drop_nxt = 1'b1;
                  end else begin
                     w_pend_nxt = 1'b1;
                  end
               end
               if (w_tick) begin
                  if (r_hold_cnt == CNT_ONE) begin
                     w_state_nxt = GAP;
                     w_hold_nxt  = '0;
                     w_gap_nxt   = GAP_LD;
                  end else begin
                     w_hold_nxt = r_hold_cnt - CNT_ONE;
                  end
               end
            end
         end
         GAP: begin
            if (w_tick && (r_gap_cnt == CNT_ONE)) begin
               w_gap_nxt = '0;
               if (r_pending) begin
                  // Queued request starts now; a same-cycle pulse takes the freed slot.
                  w_state_nxt = HOLD;
                  w_hold_nxt  = HOLD_LD;
                  w_pend_nxt  = pulse_in;
               end else if (pulse_in) begin
                  w_state_nxt = HOLD;
                  w_hold_nxt  = HOLD_LD;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               if (w_tick) begin
                  w_gap_nxt = r_gap_cnt - CNT_ONE;
               end
               if (pulse_in) begin
                  if (r_pending) begin
                     w_drop_nxt = 1'b1;
                  end else begin
                     w_pend_nxt = 1'b1;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      w_level_nxt = (w_state_nxt == HOLD);
      w_busy_nxt  = (w_state_nxt != IDLE);
   end

   assign level_out = r_level;
   assign busy_out  = r_busy;
   assign drop_out  = r_drop;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench: three stretcher configurations share one random/directed stimulus
// stream and are checked every cycle against a cycle-count reference model.
module tb_pulse_stretcher;

   logic clk = 1'b0;
   logic rst;
   logic pulse;
   logic l0, l1, l2, b0, b1, b2, d0, d1, d2;

   always #5 clk = ~clk;

   pulse_stretcher #(
      .TICK_DIV(4), .HOLD_TICKS(3), .GAP_TICKS(2), .RETRIGGER(1'b0)
   ) u_def (
      .clk_in(clk), .reset_in(rst), .pulse_in(pulse),
      .level_out(l0), .busy_out(b0), .drop_out(d0)
   );

   pulse_stretcher #(
      .TICK_DIV(4), .HOLD_TICKS(3), .GAP_TICKS(2), .RETRIGGER(1'b1)
   ) u_rtg (
      .clk_in(clk), .reset_in(rst), .pulse_in(pulse),
      .level_out(l1), .busy_out(b1), .drop_out(d1)
   );

   pulse_stretcher #(
      .TICK_DIV(1), .HOLD_TICKS(1), .GAP_TICKS(1), .RETRIGGER(1'b0)
   ) u_fast (
      .clk_in(clk), .reset_in(rst), .pulse_in(pulse),
      .level_out(l2), .busy_out(b2), .drop_out(d2)
   );

   // Model state: mode 0 idle, 1 high, 2 low gap; rem = clk cycles left in the phase.
   typedef struct {
      int unsigned mode;
      int unsigned rem;
      bit          pend;
      bit          drop;
   } mstate_t;

   typedef struct packed {
      logic [2:0] lvl;
      logic [2:0] bsy;
      logic [2:0] drp;
   } exp_t;

   int unsigned cfg_div[3]  = '{4, 4, 1};
   int unsigned cfg_hold[3] = '{3, 3, 1};
   int unsigned cfg_gap[3]  = '{2, 2, 1};
   bit          cfg_rt[3]   = '{1'b0, 1'b1, 1'b0};

   mstate_t m[3];
   exp_t    exp_q[$];
   int      n_checks = 0;
   int      n_pass = 0;

   function automatic mstate_t model_step(input mstate_t s, input bit p, input bit r,
                                          input int unsigned div, input int unsigned hold,
                                          input int unsigned gap, input bit rt);
      mstate_t n;
      n = s;
      n.drop = 1'b0;
      if (r) begin
         n.mode = 0;
         n.rem  = 0;
         n.pend = 1'b0;
         return n;
      end
      case (s.mode)
         0: begin
            if (p) begin
               n.mode = 1;
               n.rem  = hold * div;
            end
         end
         1: begin
            if (rt && p) begin
               n.rem = hold * div;
            end else begin
               if (p) begin
                  if (s.pend) n.drop = 1'b1;
                  else n.pend = 1'b1;
               end
               n.rem = s.rem - 1;
               if (n.rem == 0) begin
                  n.mode = 2;
                  n.rem  = gap * div;
               end
            end
         end
         default: begin
            if (s.rem == 1) begin
               if (s.pend) begin
                  n.mode = 1;
                  n.rem  = hold * div;
                  n.pend = p;
               end else if (p) begin
                  n.mode = 1;
                  n.rem  = hold * div;
               end else begin
                  n.mode = 0;
                  n.rem  = 0;
               end
            end else begin
               n.rem = s.rem - 1;
               if (p) begin
                  if (s.pend) n.drop = 1'b1;
                  else n.pend = 1'b1;
               end
            end
         end
      endcase
      return n;
   endfunction

   task automatic check(input string name, input int idx, input logic act, input logic exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s dut%0d at %0t: got %b, expected %b", name, idx, $time, act, exp);
      end
   endtask

   task automatic drive_cycle(input bit p, input bit r);
      exp_t e;
      @(negedge clk);
      pulse = p;
      rst   = r;
      for (int i = 0; i < 3; i++) begin
         m[i] = model_step(m[i], p, r, cfg_div[i], cfg_hold[i], cfg_gap[i], cfg_rt[i]);
         e.lvl[i] = (m[i].mode == 1);
         e.bsy[i] = (m[i].mode != 0);
         e.drp[i] = m[i].drop;
      end
      exp_q.push_back(e);
   endtask

   task automatic run_scn(input int p0, input int p1, input int p2, input int p3,
                          input int rst_at);
      drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b0, 1'b1);
      for (int c = 0; c < 80; c++) begin
         drive_cycle((c == p0) || (c == p1) || (c == p2) || (c == p3), c == rst_at);
      end
   endtask

   // Monitor: each cycle's registered outputs against the entry queued for that edge.
   always @(posedge clk) begin
      exp_t e;
      logic [2:0] act_l, act_b, act_d;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         act_l = {l2, l1, l0};
         act_b = {b2, b1, b0};
         act_d = {d2, d1, d0};
         for (int i = 0; i < 3; i++) begin
            check("level_out", i, act_l[i], e.lvl[i]);
            check("busy_out", i, act_b[i], e.bsy[i]);
            check("drop_out", i, act_d[i], e.drp[i]);
         end
      end
   end

   initial begin
      int unsigned thresh;
      rst   = 1'b1;
      pulse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m[i].mode = 0;
         m[i].rem  = 0;
         m[i].pend = 1'b0;
         m[i].drop = 1'b0;
      end
      repeat (3) drive_cycle(1'b0, 1'b1);

      run_scn(10, -1, -1, -1, -1);
      run_scn(10, 15, -1, -1, -1);
      run_scn(10, 15, 18, -1, -1);
      run_scn(10, 20, -1, -1, -1);
      run_scn(10, 20, -1, -1, 16);
      run_scn(10, 11, 12, 13, -1);

      for (int blk = 0; blk < 15; blk++) begin
         thresh = $urandom_range(70, 2);
         for (int c = 0; c < 200; c++) begin
            drive_cycle($urandom_range(99, 0) < thresh, $urandom_range(599, 0) == 0);
         end
      end
      drive_cycle(1'b0, 1'b0);
      @(posedge clk);
      #3;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
